math_divider_16bit: RTL and testbench

Sequential 16-bit unsigned restoring divider for the FSM calculator datapath; it computes quotient and remainder of `dividend / divisor`, one quotient bit per clock. It complements the ripple-carry adder: every iteration performs a trial subtraction and keeps or restores the partial remainder. The calculator control FSM starts it with a one-cycle `start` pulse and waits for a one-cycle `done` pulse.

---
 rtl/math_pkg.sv | 6 +
 rtl/math_trial_sub.sv | 19 +
 rtl/math_divider_16bit.sv | 97 +++++++++
 tb/tb_math_divider_16bit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// math_pkg: shared types and constants for the calculator math blocks
package math_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int MATH_WIDTH = 16;
  localparam logic [MATH_WIDTH-1:0] DIV_ZERO_QUOT = '1;
endpackage

// File: rtl/math_trial_sub.sv
// math_trial_sub: ripple A + ~B + 1 subtractor returning difference and borrow
module math_trial_sub #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic nb;
    assign nb        = ~b_i[i];
    assign diff_o[i] = a_i[i] ^ nb ^ c[i];
    assign c[i+1]    = (a_i[i] & nb) | (a_i[i] & c[i]) | (nb & c[i]);
  end
  assign borrow_o = ~c[WIDTH];
endmodule

// File: rtl/math_divider_16bit.sv
// math_divider_16bit: sequential unsigned restoring divider, one quotient bit per clock
module math_divider_16bit
  import math_pkg::*;
#(
  parameter int WIDTH = MATH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  div_state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH:0] r_q, r_d, r_shift, diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, borrow;
  logic unused_rtop;
  // R stays below D after every iteration, so its top bit never feeds the next shift
  assign unused_rtop = r_q[WIDTH];
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  math_trial_sub #(.WIDTH(WIDTH+1)) u_sub (
    .a_i(r_shift),
    .b_i({1'b0, d_q}),
    .diff_o(diff),
    .borrow_o(borrow)
  );
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        if (divisor != '0) begin
          state_d = CALC;
          q_d     = dividend;
          r_d     = '0;
          d_d     = divisor;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
          quot_d  = WIDTH'($signed(DIV_ZERO_QUOT));
          rem_d   = dividend;
          dbz_d   = 1'b1;
        end
      end
      CALC: begin
        r_d   = borrow ? r_shift : diff;
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          quot_d  = {q_q[WIDTH-2:0], ~borrow};
          rem_d   = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  assign busy        = state_q == CALC;
  assign done        = state_q == DONE;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_math_divider_16bit.sv
// tb_math_divider_16bit: directed self-checking bench for the restoring divider
module tb_math_divider_16bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int n_checks = 0;
  int n_fail = 0;

  math_divider_16bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_quot"}, quotient, 0);
    check({tag, "_rem"}, remainder, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask

  // cyc: sample (negedge after the accept edge, counting from 1) where done is first seen
  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez,
                        input int ecyc, input int ebusy);
    int cyc = 0;
    int nbusy = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        seen = 1;
        cyc = i;
        check({tag, "_busy_at_done"}, busy, 0);
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, ecyc);
    check({tag, "_busy_cycles"}, nbusy, ebusy);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int ndone;
    logic [15:0] q_first, r_first;
    #1 check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_div("100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
    do_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 16);
    do_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17, 16);
    do_div("3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 16);
    do_div("0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 17, 16);
    do_div("5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0);
    do_div("9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 16);
    do_div("12345_67", 16'd12345, 16'd67, 16'd184, 16'd17, 1'b0, 17, 16);

    // a start pulse during CALC must be dropped
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; q_first = '0; r_first = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (ndone == 0) begin q_first = quotient; r_first = remainder; end
        ndone++;
      end
      @(negedge clk);
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_quot", q_first, 16'd333);
    check("ignore_rem", r_first, 16'd1);

    // asynchronous reset mid-operation aborts without done
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_ndone", ndone, 0);
    check_idle_zero("after_abort");
    do_div("after_1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
